// File: rtl/cbd_poly_scheduler_if.sv
// Handshake/data bundle around the CBD polynomial scheduler: command port,
// PRF request, sampler control/beat input and write-buffer strobe.
interface cbd_poly_scheduler_if #(
    parameter int DATA_W = 48
);
    logic              cmd_valid;
    logic              cmd_ready;
    logic [2:0]        cmd_k;
    logic              cmd_eta3;
    logic [7:0]        cmd_nonce;
    logic              prf_req;
    logic [7:0]        prf_nonce;
    logic              prf_ack;
    logic              cbd_start;
    logic              cbd_n;
    logic              cbd_done;
    logic [DATA_W-1:0] cbd_out;
    logic              wb_valid;
    logic [DATA_W-1:0] wb_data;
    logic [7:0]        wb_addr;
    logic              busy;
    logic              sched_done;
    logic              err;

    modport slave (
        input  cmd_valid, cmd_k, cmd_eta3, cmd_nonce, prf_ack, cbd_done, cbd_out,
        output cmd_ready, prf_req, prf_nonce, cbd_start, cbd_n,
               wb_valid, wb_data, wb_addr, busy, sched_done, err
    );

    modport master (
        output cmd_valid, cmd_k, cmd_eta3, cmd_nonce, prf_ack, cbd_done, cbd_out,
        input  cmd_ready, prf_req, prf_nonce, cbd_start, cbd_n,
               wb_valid, wb_data, wb_addr, busy, sched_done, err
    );
endinterface

// File: rtl/cbd_poly_scheduler.sv
// Sequences the CBD sampler over k noise polynomials, tagging each beat with {poly, beat}.
// Optional RUN-state watchdog enabled by defining CBD_SCHED_TIMEOUT_EN.
module cbd_poly_scheduler #(
    parameter int MAX_K          = 4,
    parameter int BEATS_PER_POLY = 64,
    parameter int DATA_W         = 48,
    parameter int TIMEOUT_CYCLES = 1024
) (
    input  logic                  clk,
    input  logic                  reset,
    cbd_poly_scheduler_if.slave   bus
);
    localparam int BW = $clog2(BEATS_PER_POLY);

    localparam logic [2:0] S_IDLE   = 3'd0;
    localparam logic [2:0] S_REQ    = 3'd1;
    localparam logic [2:0] S_RUN    = 3'd2;
    localparam logic [2:0] S_GAP    = 3'd3;
    localparam logic [2:0] S_FINISH = 3'd4;

    if (MAX_K < 1 || MAX_K > 7 || BEATS_PER_POLY < 2 || TIMEOUT_CYCLES < 1) begin : g_bad_cfg
        $error("cbd_poly_scheduler: unsupported parameter set");
    end

    logic [2:0]        state_q, state_d;
    logic [2:0]        k_q, k_d;
    logic              eta3_q, eta3_d;
    logic [7:0]        nonce_q, nonce_d;
    logic [2:0]        poly_idx_q, poly_idx_d;
    logic [BW-1:0]     beat_q, beat_d;
    logic              busy_q, busy_d;
    logic              done_q, done_d;
    logic              err_q, err_d;
    logic              wb_valid_q, wb_valid_d;
    logic [DATA_W-1:0] wb_data_q, wb_data_d;
    logic [7:0]        wb_addr_q, wb_addr_d;
    logic [2:0]        k_clamped;

`ifdef CBD_SCHED_TIMEOUT_EN
    localparam int WD_W = $clog2(TIMEOUT_CYCLES + 1);
    logic [WD_W-1:0]   wd_q, wd_d;
`endif

    assign k_clamped = (bus.cmd_k > 3'(MAX_K)) ? 3'(MAX_K) : bus.cmd_k;

    always_comb begin
        state_d    = state_q;
        k_d        = k_q;
        eta3_d     = eta3_q;
        nonce_d    = nonce_q;
        poly_idx_d = poly_idx_q;
        beat_d     = beat_q;
        busy_d     = busy_q;
        done_d     = 1'b0;
        err_d      = err_q;
        wb_valid_d = 1'b0;
        wb_data_d  = wb_data_q;
        wb_addr_d  = wb_addr_q;
`ifdef CBD_SCHED_TIMEOUT_EN
        wd_d       = wd_q;
`endif
        case (state_q)
            S_IDLE: begin
                if (bus.cmd_valid) begin
                    k_d        = k_clamped;
                    eta3_d     = bus.cmd_eta3;
                    nonce_d    = bus.cmd_nonce;
                    poly_idx_d = 3'd0;
                    err_d      = 1'b0;
                    busy_d     = 1'b1;
                    state_d    = (k_clamped == 3'd0) ? S_FINISH : S_REQ;
                end
            end
            S_REQ: begin
                if (bus.prf_ack) begin
                    beat_d  = '0;
                    state_d = S_RUN;
`ifdef CBD_SCHED_TIMEOUT_EN
                    wd_d    = '0;
`endif
                end
            end
            S_RUN: begin
                if (bus.cbd_done) begin
                    wb_valid_d = 1'b1;
                    wb_data_d  = bus.cbd_out;
                    wb_addr_d  = 8'({poly_idx_q[1:0], beat_q});
                    beat_d     = beat_q + 1'b1;
`ifdef CBD_SCHED_TIMEOUT_EN
                    wd_d       = '0;
`endif
                    if (beat_q == BW'(BEATS_PER_POLY - 1)) begin
                        state_d = S_GAP;
                    end
                end
`ifdef CBD_SCHED_TIMEOUT_EN
                // A stalled sampler abandons the rest of the vector but still completes the command.
                else if (wd_q == WD_W'(TIMEOUT_CYCLES - 1)) begin
                    err_d   = 1'b1;
                    state_d = S_FINISH;
                end else begin
                    wd_d = wd_q + 1'b1;
                end
`endif
            end
            S_GAP: begin
                poly_idx_d = poly_idx_q + 3'd1;
                state_d    = (poly_idx_q == k_q - 3'd1) ? S_FINISH : S_REQ;
            end
            S_FINISH: begin
                busy_d  = 1'b0;
                done_d  = 1'b1;
                state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
        // Any sampler beat outside RUN is dropped and flagged, even on the accept cycle.
        if (bus.cbd_done && state_q != S_RUN) begin
            err_d = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= S_IDLE;
            k_q        <= '0;
            eta3_q     <= 1'b0;
            nonce_q    <= '0;
            poly_idx_q <= '0;
            beat_q     <= '0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            err_q      <= 1'b0;
            wb_valid_q <= 1'b0;
            wb_data_q  <= '0;
            wb_addr_q  <= '0;
`ifdef CBD_SCHED_TIMEOUT_EN
            wd_q       <= '0;
`endif
        end else begin
            state_q    <= state_d;
            k_q        <= k_d;
            eta3_q     <= eta3_d;
            nonce_q    <= nonce_d;
            poly_idx_q <= poly_idx_d;
            beat_q     <= beat_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
            err_q      <= err_d;
            wb_valid_q <= wb_valid_d;
            wb_data_q  <= wb_data_d;
            wb_addr_q  <= wb_addr_d;
`ifdef CBD_SCHED_TIMEOUT_EN
            wd_q       <= wd_d;
`endif
        end
    end

    assign bus.cmd_ready  = (state_q == S_IDLE);
    assign bus.prf_req    = (state_q == S_REQ);
    assign bus.prf_nonce  = (state_q == S_REQ) ? (nonce_q + 8'(poly_idx_q)) : 8'd0;
    assign bus.cbd_start  = (state_q == S_RUN);
    assign bus.cbd_n      = eta3_q;
    assign bus.wb_valid   = wb_valid_q;
    assign bus.wb_data    = wb_data_q;
    assign bus.wb_addr    = wb_addr_q;
    assign bus.busy       = busy_q;
    assign bus.sched_done = done_q;
    assign bus.err        = err_q;
endmodule

// File: tb/tb_cbd_poly_scheduler.sv
// Directed bench for cbd_poly_scheduler; define CBD_SCHED_TIMEOUT_EN to also exercise the watchdog.
module tb_cbd_poly_scheduler;
    logic clk;
    logic reset;
    int   n_cmp;
    int   n_bad;

    cbd_poly_scheduler_if #(.DATA_W(48)) bus ();

    cbd_poly_scheduler #(
        .MAX_K(4), .BEATS_PER_POLY(64), .DATA_W(48), .TIMEOUT_CYCLES(1024)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [47:0] pat(input int p, input int b);
        logic [7:0] pp, bb;
        pp = 8'(p);
        bb = 8'(b);
        return {8'hC3 ^ pp, bb, 16'hBEEF, 8'(b * 3 + p), pp ^ bb};
    endfunction

    task automatic chk_idle(input string tag);
        chk({tag, "_cmd_ready"},  64'(bus.cmd_ready),  64'd1);
        chk({tag, "_prf_req"},    64'(bus.prf_req),    64'd0);
        chk({tag, "_prf_nonce"},  64'(bus.prf_nonce),  64'd0);
        chk({tag, "_cbd_start"},  64'(bus.cbd_start),  64'd0);
        chk({tag, "_cbd_n"},      64'(bus.cbd_n),      64'd0);
        chk({tag, "_wb_valid"},   64'(bus.wb_valid),   64'd0);
        chk({tag, "_wb_data"},    64'(bus.wb_data),    64'd0);
        chk({tag, "_wb_addr"},    64'(bus.wb_addr),    64'd0);
        chk({tag, "_busy"},       64'(bus.busy),       64'd0);
        chk({tag, "_sched_done"}, 64'(bus.sched_done), 64'd0);
        chk({tag, "_err"},        64'(bus.err),        64'd0);
    endtask

    task automatic send_cmd(input logic [2:0] k, input logic eta3, input logic [7:0] nonce);
        chk("cmd_ready_before_accept", 64'(bus.cmd_ready), 64'd1);
        bus.cmd_valid = 1'b1;
        bus.cmd_k     = k;
        bus.cmd_eta3  = eta3;
        bus.cmd_nonce = nonce;
        tick();
        bus.cmd_valid = 1'b0;
        chk("busy_after_accept", 64'(bus.busy), 64'd1);
        chk("cmd_ready_busy", 64'(bus.cmd_ready), 64'd0);
    endtask

    task automatic req_phase(input logic [7:0] nonce, input int delay, input logic eta);
        chk("prf_req", 64'(bus.prf_req), 64'd1);
        chk("prf_nonce", 64'(bus.prf_nonce), 64'(nonce));
        chk("cbd_start_in_req", 64'(bus.cbd_start), 64'd0);
        for (int d = 0; d < delay; d++) begin
            bus.prf_ack = 1'b0;
            tick();
            chk("prf_req_held", 64'(bus.prf_req), 64'd1);
            chk("prf_nonce_held", 64'(bus.prf_nonce), 64'(nonce));
            chk("cbd_start_before_ack", 64'(bus.cbd_start), 64'd0);
            chk("cbd_n_req", 64'(bus.cbd_n), 64'(eta));
        end
        bus.prf_ack = 1'b1;
        tick();
        bus.prf_ack = 1'b0;
        chk("cbd_start_run", 64'(bus.cbd_start), 64'd1);
        chk("prf_req_dropped", 64'(bus.prf_req), 64'd0);
        chk("cbd_n_run", 64'(bus.cbd_n), 64'(eta));
    endtask

    task automatic run_beats(input int p, input int n);
        logic [1:0] pa;
        logic [5:0] ba;
        pa = 2'(p);
        for (int b = 0; b < n; b++) begin
            ba = 6'(b);
            bus.cbd_done = 1'b1;
            bus.cbd_out  = pat(p, b);
            tick();
            chk("wb_valid", 64'(bus.wb_valid), 64'd1);
            chk("wb_addr", 64'(bus.wb_addr), 64'({pa, ba}));
            chk("wb_data", 64'(bus.wb_data), 64'(pat(p, b)));
        end
        bus.cbd_done = 1'b0;
        bus.cbd_out  = '0;
    endtask

    task automatic gap_step();
        chk("cbd_start_gap", 64'(bus.cbd_start), 64'd0);
        chk("busy_gap", 64'(bus.busy), 64'd1);
        tick();
        chk("wb_valid_after_gap", 64'(bus.wb_valid), 64'd0);
    endtask

    task automatic fin(input logic exp_err);
        chk("sched_done_early", 64'(bus.sched_done), 64'd0);
        chk("cmd_ready_finish", 64'(bus.cmd_ready), 64'd0);
        chk("cbd_start_finish", 64'(bus.cbd_start), 64'd0);
        tick();
        chk("sched_done_pulse", 64'(bus.sched_done), 64'd1);
        chk("busy_done", 64'(bus.busy), 64'd0);
        chk("err_done", 64'(bus.err), 64'(exp_err));
        chk("cmd_ready_done", 64'(bus.cmd_ready), 64'd1);
        tick();
        chk("sched_done_single", 64'(bus.sched_done), 64'd0);
    endtask

    initial begin
        n_cmp = 0;
        n_bad = 0;
        reset = 1'b1;
        bus.cmd_valid = 1'b0;
        bus.cmd_k     = '0;
        bus.cmd_eta3  = 1'b0;
        bus.cmd_nonce = '0;
        bus.prf_ack   = 1'b0;
        bus.cbd_done  = 1'b0;
        bus.cbd_out   = '0;
        tick();
        tick();
        reset = 1'b0;
        chk_idle("reset");

        // k=2, eta=2, nonce 0x10: two polys, addresses 0x00..0x7F
        send_cmd(3'd2, 1'b0, 8'h10);
        for (int p = 0; p < 2; p++) begin
            req_phase(8'(8'h10 + p), 0, 1'b0);
            run_beats(p, 64);
            gap_step();
        end
        fin(1'b0);

        // k=1, eta=3, PRF ack delayed 5 cycles
        send_cmd(3'd1, 1'b1, 8'h33);
        req_phase(8'h33, 5, 1'b1);
        run_beats(0, 64);
        chk("cbd_n_after_run", 64'(bus.cbd_n), 64'd1);
        gap_step();
        fin(1'b0);

        // k=0: empty command, done pulse two cycles after accept, no traffic
        send_cmd(3'd0, 1'b0, 8'h55);
        chk("k0_prf_req", 64'(bus.prf_req), 64'd0);
        chk("k0_wb_valid", 64'(bus.wb_valid), 64'd0);
        fin(1'b0);

        // nonce wrap: FE, FF, 00
        send_cmd(3'd3, 1'b0, 8'hFE);
        req_phase(8'hFE, 0, 1'b0);
        run_beats(0, 64);
        gap_step();
        req_phase(8'hFF, 1, 1'b0);
        run_beats(1, 64);
        gap_step();
        req_phase(8'h00, 0, 1'b0);
        run_beats(2, 64);
        gap_step();
        fin(1'b0);

        // cmd_k=6 is clamped to MAX_K=4 polynomials
        send_cmd(3'd6, 1'b0, 8'h80);
        for (int p = 0; p < 4; p++) begin
            req_phase(8'(8'h80 + p), 0, 1'b0);
            run_beats(p, 64);
            gap_step();
        end
        fin(1'b0);

        // reset at beat 30 of poly 1 aborts with no done pulse
        send_cmd(3'd2, 1'b1, 8'h20);
        req_phase(8'h20, 0, 1'b1);
        run_beats(0, 64);
        gap_step();
        req_phase(8'h21, 0, 1'b1);
        run_beats(1, 30);
        bus.cbd_done = 1'b1;
        bus.cbd_out  = pat(1, 30);
        reset = 1'b1;
        tick();
        reset = 1'b0;
        bus.cbd_done = 1'b0;
        chk_idle("abort");
        tick();
        chk_idle("abort_next");

        // stray beat in IDLE: dropped, sticky err, cleared by next accept
        bus.cbd_done = 1'b1;
        bus.cbd_out  = 48'h123456789ABC;
        tick();
        bus.cbd_done = 1'b0;
        chk("stray_idle_wb_valid", 64'(bus.wb_valid), 64'd0);
        chk("stray_idle_err", 64'(bus.err), 64'd1);
        tick();
        chk("stray_err_sticky", 64'(bus.err), 64'd1);
        send_cmd(3'd0, 1'b0, 8'h00);
        chk("err_cleared_on_accept", 64'(bus.err), 64'd0);
        fin(1'b0);

        // stray beat coinciding with prf_ack
        send_cmd(3'd1, 1'b0, 8'h40);
        chk("stray_req_prf_req", 64'(bus.prf_req), 64'd1);
        bus.prf_ack  = 1'b1;
        bus.cbd_done = 1'b1;
        bus.cbd_out  = 48'hFFFF_0000_FFFF;
        tick();
        bus.prf_ack  = 1'b0;
        bus.cbd_done = 1'b0;
        chk("stray_req_wb_valid", 64'(bus.wb_valid), 64'd0);
        chk("stray_req_err", 64'(bus.err), 64'd1);
        chk("stray_req_cbd_start", 64'(bus.cbd_start), 64'd1);
        run_beats(0, 64);
        gap_step();
        fin(1'b1);

`ifdef CBD_SCHED_TIMEOUT_EN
        // watchdog: 1024 idle cycles in RUN forces FINISH with err
        send_cmd(3'd2, 1'b0, 8'h90);
        req_phase(8'h90, 0, 1'b0);
        for (int c = 0; c < 1023; c++) tick();
        chk("wd_still_run", 64'(bus.cbd_start), 64'd1);
        chk("wd_err_before", 64'(bus.err), 64'd0);
        tick();
        chk("wd_err", 64'(bus.err), 64'd1);
        chk("wd_prf_req_skipped", 64'(bus.prf_req), 64'd0);
        fin(1'b1);
`else
        // without the watchdog RUN waits indefinitely for beats
        send_cmd(3'd1, 1'b0, 8'h90);
        req_phase(8'h90, 0, 1'b0);
        for (int c = 0; c < 1100; c++) tick();
        chk("stall_still_run", 64'(bus.cbd_start), 64'd1);
        chk("stall_no_err", 64'(bus.err), 64'd0);
        run_beats(0, 64);
        gap_step();
        fin(1'b0);
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
